// File: rtl/temp_bcd_convert.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// temp_bcd_convert
//
// Converts a DS18B20 scratchpad temperature word into display values:
//   - a rounded integer temperature clamped to 0..29 for the display stage,
//   - a two-digit BCD magnitude (clamped to 99) built by a sequential
//     shift-add-3 (double dabble) converter, one shift per clock,
//   - a sign flag and an over-range flag.
//
// Ports
//   clk_1khz  in   1   single clock, rising edge
//   rst       in   1   synchronous active-high reset
//   raw_temp  in  16   two's complement, 4 fractional bits (LSB = 1/16 degC)
//   raw_valid in   1   one-cycle strobe qualifying raw_temp
//   data      out  5   rounded temperature clamped to 0..29
//   bcd_tens  out  4   tens digit of min(magnitude, 99)
//   bcd_ones  out  4   ones digit of min(magnitude, 99)
//   neg       out  1   last accepted sample was below zero
//   over      out  1   last rounded magnitude exceeded 29
//   busy      out  1   conversion in progress (state is CONV)
//   done      out  1   one-cycle pulse; outputs updated in the same cycle
//
// Handshake: raw_valid is a one-cycle strobe with no ready. It is accepted
// only when busy=0 and rst=0; any strobe seen while busy=1 is dropped, not
// queued. A strobe coinciding with done is accepted, since the FSM is back
// in IDLE in that cycle.
//
// Timing: capture edge E0 enters CONV; edges E1..E7 each perform one
// double-dabble shift; at E7 the results are registered, the FSM returns to
// IDLE and done is high for the following cycle only. busy mirrors the FSM
// state, so it is the observable view of the two-state controller.
// ---------------------------------------------------------------------------
module temp_bcd_convert (
  input  logic        clk_1khz,
  input  logic        rst,
  input  logic [15:0] raw_temp,
  input  logic        raw_valid,
  output logic [4:0]  data,
  output logic [3:0]  bcd_tens,
  output logic [3:0]  bcd_ones,
  output logic        neg,
  output logic        over,
  output logic        busy,
  output logic        done
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam logic [2:0] LAST_ITER = 3'd6;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  iter_q;
  // Double-dabble working register: {tens[3:0], ones[3:0], bin[6:0]}.
  logic [14:0] shift_q;
  logic [14:0] shift_next;

  // Results computed at capture and held until the conversion completes,
  // so that nothing of the new sample reaches the outputs before done.
  logic [4:0]  pend_data_q;
  logic        pend_neg_q;
  logic        pend_over_q;

  logic        capture;
  logic        finish;

  // -------------------------------------------------------------------------
  // Magnitude rules applied to the incoming word
  // -------------------------------------------------------------------------
  logic [7:0]  mag_sum;
  logic        mag_hi;
  logic [6:0]  mag;
  logic [6:0]  bcd_in;
  logic [4:0]  data_in;
  logic        over_in;
  logic        unused_frac;

  // Bits below the rounding bit only matter for rounding through bit 3.
  assign unused_frac = ^raw_temp[2:0];

  // Round half up: integer part plus the 0.5 bit.
  assign mag_sum = {1'b0, raw_temp[10:4]} + {7'd0, raw_temp[3]};
  // A positive word with integer bits above bit 10 is already beyond 127.
  assign mag_hi  = |raw_temp[14:11];

  always_comb begin
    mag = 7'd0;
    if (!raw_temp[15]) begin
      if (mag_hi || mag_sum[7]) begin
        mag = 7'd127;
      end else begin
        mag = mag_sum[6:0];
      end
    end
  end

  assign bcd_in  = (mag > 7'd99) ? 7'd99 : mag;
  assign data_in = (mag > 7'd29) ? 5'd29 : mag[4:0];
  assign over_in = (mag > 7'd29);

  // -------------------------------------------------------------------------
  // One double-dabble iteration: add 3 to any digit >= 5, then shift left.
  // -------------------------------------------------------------------------
  logic [3:0] tens_adj;
  logic [3:0] ones_adj;

  always_comb begin
    tens_adj = shift_q[14:11];
    ones_adj = shift_q[10:7];
    if (shift_q[14:11] >= 4'd5) begin
      tens_adj = shift_q[14:11] + 4'd3;
    end
    if (shift_q[10:7] >= 4'd5) begin
      ones_adj = shift_q[10:7] + 4'd3;
    end
    shift_next = {tens_adj[2:0], ones_adj, shift_q[6:0], 1'b0};
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (raw_valid) begin
          capture = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        if (iter_q == LAST_ITER) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State, datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_1khz) begin
    if (rst) begin
      state_q     <= IDLE;
      iter_q      <= 3'd0;
      shift_q     <= 15'd0;
      pend_data_q <= 5'd0;
      pend_neg_q  <= 1'b0;
      pend_over_q <= 1'b0;
      data        <= 5'd0;
      bcd_tens    <= 4'd0;
      bcd_ones    <= 4'd0;
      neg         <= 1'b0;
      over        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= finish;
      if (capture) begin
        shift_q     <= {8'd0, bcd_in};
        iter_q      <= 3'd0;
        pend_data_q <= data_in;
        pend_neg_q  <= raw_temp[15];
        pend_over_q <= over_in;
      end else if (state_q == CONV) begin
        shift_q <= shift_next;
        if (finish) begin
          iter_q   <= 3'd0;
          // The seventh shift completes here; take the digits straight
          // from the shifter so the outputs never show partial values.
          bcd_tens <= shift_next[14:11];
          bcd_ones <= shift_next[10:7];
          data     <= pend_data_q;
          neg      <= pend_neg_q;
          over     <= pend_over_q;
        end else begin
          iter_q <= iter_q + 3'd1;
        end
      end
    end
  end

  assign busy = (state_q == CONV);

endmodule
